// File: rtl/elastic_operator_if.sv
// Handshake bundle for elastic_operator: upstream pull port, downstream fan-out port and status.
// The slave modport is the operator side; the master modport is the environment side.
interface elastic_operator_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INPUT_SIZE  = 2,
    parameter int unsigned OUTPUT_SIZE = 1
);
    logic [INPUT_SIZE-1:0]            req_l;
    logic [INPUT_SIZE-1:0]            ack_l;
    logic [DATA_WIDTH*INPUT_SIZE-1:0] din;
    logic [OUTPUT_SIZE-1:0]           req_r;
    logic [OUTPUT_SIZE-1:0]           ack_r;
    logic [DATA_WIDTH-1:0]            dout;
    logic [31:0]                      fire_count;
    logic                             overflow;

    modport master (
        input  req_l, ack_r, dout, fire_count, overflow,
        output ack_l, din, req_r
    );

    modport slave (
        output req_l, ack_r, dout, fire_count, overflow,
        input  ack_l, din, req_r
    );
endinterface

// File: rtl/elastic_operator.sv
// Elastic N-input operator: per-input FIFOs feed a combinational OP, the result is
// held and delivered once to each of OUTPUT_SIZE independently handshaken consumers.
module elastic_operator #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           INPUT_SIZE  = 2,
    parameter int unsigned           OUTPUT_SIZE = 1,
    parameter int unsigned           DEPTH       = 4,
    parameter string                 OP          = "add",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
    input logic                clk,
    input logic                rst,
    elastic_operator_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        OP_PASS, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD, OP_SUB, OP_MUL, OP_MIN, OP_MAX
    } op_e;

    localparam op_e OP_SEL =
        (OP == "addi") ? OP_ADDI :
        (OP == "subi") ? OP_SUBI :
        (OP == "muli") ? OP_MULI :
        (OP == "add")  ? OP_ADD  :
        (OP == "sub")  ? OP_SUB  :
        (OP == "mul")  ? OP_MUL  :
        (OP == "min")  ? OP_MIN  :
        (OP == "max")  ? OP_MAX  : OP_PASS;

    typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

    logic [DATA_WIDTH-1:0]  mem_q    [INPUT_SIZE][DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d    [INPUT_SIZE][DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [INPUT_SIZE];
    logic [PTR_W-1:0]       wr_ptr_d [INPUT_SIZE];
    logic [PTR_W-1:0]       rd_ptr_q [INPUT_SIZE];
    logic [PTR_W-1:0]       rd_ptr_d [INPUT_SIZE];
    logic [CNT_W-1:0]       count_q  [INPUT_SIZE];
    logic [CNT_W-1:0]       count_d  [INPUT_SIZE];
    logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;
    logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
    logic [OUTPUT_SIZE-1:0] served_q, served_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic [31:0]            fire_count_q, fire_count_d;
    logic                   overflow_q, overflow_d;
    state_e                 state_q, state_d;

    logic [DATA_WIDTH-1:0]  heads [INPUT_SIZE];
    logic [INPUT_SIZE-1:0]  push;
    logic                   all_ready;
    logic                   fire;
    logic [DATA_WIDTH-1:0]  result;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin : head_select
        all_ready = 1'b1;
        for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
            heads[i] = mem_q[i][rd_ptr_q[i]];
            if (count_q[i] == '0) all_ready = 1'b0;
        end
        fire = (state_q == ST_EMPTY) && all_ready;
    end

    // Channel 0 seeds the accumulator so it is always the first operand.
    always_comb begin : operate
        result = heads[0];
        case (OP_SEL)
            OP_ADDI: result = heads[0] + IMMEDIATE;
            OP_SUBI: result = heads[0] - IMMEDIATE;
            OP_MULI: result = heads[0] * IMMEDIATE;
            OP_ADD:  for (int unsigned i = 1; i < INPUT_SIZE; i++) result = result + heads[i];
            OP_SUB:  for (int unsigned i = 1; i < INPUT_SIZE; i++) result = result - heads[i];
            OP_MUL:  for (int unsigned i = 1; i < INPUT_SIZE; i++) result = result * heads[i];
            OP_MIN:  for (int unsigned i = 1; i < INPUT_SIZE; i++) if (heads[i] < result) result = heads[i];
            OP_MAX:  for (int unsigned i = 1; i < INPUT_SIZE; i++) if (heads[i] > result) result = heads[i];
            default: result = heads[0];
        endcase
    end

    always_comb begin : next_state
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        push         = '0;
        req_l_d      = req_l_q;
        overflow_d   = overflow_q;
        state_d      = state_q;
        served_d     = served_q;
        ack_r_d      = '0;
        dout_d       = dout_q;
        fire_count_d = fire_count_q;

        // A full FIFO still accepts a word when the same edge pops its head.
        for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
            push[i] = bus.ack_l[i] && ((count_q[i] != CNT_W'(DEPTH)) || fire);
            if (bus.ack_l[i] && !push[i]) overflow_d = 1'b1;
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = bus.din[DATA_WIDTH*i +: DATA_WIDTH];
                wr_ptr_d[i]           = next_ptr(wr_ptr_q[i]);
            end
            if (fire) rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
            if (push[i] && !fire)      count_d[i] = count_q[i] + 1'b1;
            else if (!push[i] && fire) count_d[i] = count_q[i] - 1'b1;
            req_l_d[i] = (count_d[i] <= CNT_W'(DEPTH - 2));
        end

        if (state_q == ST_EMPTY) begin
            if (fire) begin
                state_d      = ST_HOLD;
                served_d     = '0;
                dout_d       = result;
                fire_count_d = fire_count_q + 32'd1;
            end
        end else begin
            if (&served_q) state_d = ST_EMPTY;
            for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
                if (bus.req_r[j] && !served_q[j] && !ack_r_q[j]) begin
                    ack_r_d[j]  = 1'b1;
                    served_d[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            req_l_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_EMPTY;
            served_q     <= '0;
            ack_r_q      <= '0;
            dout_q       <= '0;
            fire_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            req_l_q      <= req_l_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            served_q     <= served_d;
            ack_r_q      <= ack_r_d;
            dout_q       <= dout_d;
            fire_count_q <= fire_count_d;
        end
        mem_q <= mem_d;
    end

    assign bus.req_l      = req_l_q;
    assign bus.ack_r      = ack_r_q;
    assign bus.dout       = dout_q;
    assign bus.fire_count = fire_count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_elastic_operator.sv
// Randomized bench for elastic_operator: a queue-based model of the add operator with
// three consumers, plus small subi/max instances checked against literal results.
module tb_elastic_operator;
    localparam int unsigned DW = 32;
    localparam int unsigned NI = 2;
    localparam int unsigned NO = 3;
    localparam int unsigned DP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elastic_operator_if #(.DATA_WIDTH(DW), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO)) bus ();
    elastic_operator_if #(.DATA_WIDTH(DW), .INPUT_SIZE(1),  .OUTPUT_SIZE(1))  bs ();
    elastic_operator_if #(.DATA_WIDTH(DW), .INPUT_SIZE(3),  .OUTPUT_SIZE(1))  bm ();

    elastic_operator #(.DATA_WIDTH(DW), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .DEPTH(DP),
                       .OP("add"), .IMMEDIATE(32'd0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    elastic_operator #(.DATA_WIDTH(DW), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2),
                       .OP("subi"), .IMMEDIATE(32'd5))
        dut_subi (.clk(clk), .rst(rst), .bus(bs));
    elastic_operator #(.DATA_WIDTH(DW), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(4),
                       .OP("max"), .IMMEDIATE(32'd0))
        dut_max (.clk(clk), .rst(rst), .bus(bm));

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues per input, one held result with a delivered-to set.
    logic [31:0]   mq [NI][$];
    bit            m_hold;
    logic [NO-1:0] m_served, m_ack;
    logic [31:0]   m_dout, m_fc;
    bit            m_ovf;
    logic [NI-1:0] m_reql;

    always @(posedge clk) begin : model
        logic [NO-1:0] nack;
        logic [31:0]   r;
        if (rst) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            m_hold = 0; m_served = '0; m_ack = '0; m_dout = '0; m_fc = '0; m_ovf = 0; m_reql = '0;
        end else begin
            nack = '0;
            if (m_hold) begin
                for (int j = 0; j < NO; j++)
                    if (bus.req_r[j] && !m_served[j] && !m_ack[j]) nack[j] = 1'b1;
                if (m_served == {NO{1'b1}}) m_hold = 0;
                m_served = m_served | nack;
            end else if (mq[0].size() > 0 && mq[1].size() > 0) begin
                r = 0;
                for (int i = 0; i < NI; i++) r = r + mq[i].pop_front();
                m_dout = r; m_hold = 1; m_served = '0; m_fc = m_fc + 1;
            end
            m_ack = nack;
            for (int i = 0; i < NI; i++)
                if (bus.ack_l[i]) begin
                    if (mq[i].size() < DP) mq[i].push_back(bus.din[32*i +: 32]);
                    else m_ovf = 1;
                end
            for (int i = 0; i < NI; i++) m_reql[i] = (mq[i].size() <= DP - 2);
        end
    end

    logic [NO-1:0] prev_ack = '0;
    int            lit_idx = 0;
    logic [31:0]   lits [3] = '{32'd10, 32'd21, 32'd32};

    always @(negedge clk) begin
        if (checking) begin
            chk("req_l", 32'(bus.req_l), 32'(m_reql));
            chk("ack_r", 32'(bus.ack_r), 32'(m_ack));
            chk("dout", bus.dout, m_dout);
            chk("fire_count", bus.fire_count, m_fc);
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("ack_r_no_repeat", 32'(bus.ack_r & prev_ack), 32'd0);
            prev_ack = bus.ack_r;
            if (bus.ack_r[0] && lit_idx < 3) begin
                chk("first_results", bus.dout, lits[lit_idx]);
                lit_idx++;
            end
        end
    end

    int            prod_pct = 0;
    int            cons_pct = 0;
    bit            prod_force = 0;
    logic [NO-1:0] cons_en = '0;
    int unsigned   cnt0 = 0;
    int unsigned   cnt1 = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            logic a;
            a = ($urandom_range(99) < prod_pct) && (prod_force || bus.req_l[i]);
            bus.ack_l[i] = a;
            if (a) begin
                if (i == 0) begin bus.din[31:0] = cnt0; cnt0++; end
                else begin bus.din[63:32] = 10 * (cnt1 + 1); cnt1++; end
            end
        end
        for (int j = 0; j < NO; j++)
            bus.req_r[j] = cons_en[j] && ($urandom_range(99) < cons_pct);
    endtask

    logic [31:0] sub_in  [2] = '{32'd3, 32'd10};
    logic [31:0] sub_exp [2] = '{32'hFFFF_FFFE, 32'd5};
    logic [95:0] mx_in   [2] = '{{32'd2, 32'd9, 32'd7}, {32'd8, 32'd3, 32'd12}};
    logic [31:0] mx_exp  [2] = '{32'd9, 32'd12};

    initial begin
        bit got;
        bus.ack_l = '0; bus.din = '0; bus.req_r = '0;
        bs.ack_l = '0;  bs.din = '0;  bs.req_r = '0;
        bm.ack_l = '0;  bm.din = '0;  bm.req_r = '0;
        rst = 1'b1;
        repeat (3) cycle();
        checking = 1'b1;
        chk("reset_req_l", 32'(bus.req_l), 32'd0);
        chk("reset_ack_r", 32'(bus.ack_r), 32'd0);
        chk("reset_dout", bus.dout, 32'd0);
        chk("reset_fire_count", bus.fire_count, 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;

        // Rate-limited producers and consumers.
        prod_pct = 70; cons_en = '1; cons_pct = 60;
        repeat (300) cycle();

        // Consumer 2 lags by 10 cycles per result.
        prod_pct = 100; cons_pct = 100;
        repeat (4) begin
            cons_en = 3'b011; repeat (10) cycle();
            cons_en = 3'b111; repeat (6) cycle();
        end

        // Long downstream stall: backpressure without loss.
        cons_en = '0;
        repeat (50) cycle();
        chk("stall_req_l", 32'(bus.req_l), 32'd0);
        chk("stall_overflow", 32'(bus.overflow), 32'd0);
        cons_en = '1;
        repeat (60) cycle();

        // Producers ignore req_l into full FIFOs.
        cons_en = '0; prod_force = 1;
        repeat (10) cycle();
        chk("forced_overflow", 32'(bus.overflow), 32'd1);
        prod_force = 0; cons_en = '1;
        repeat (40) cycle();
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Reset while holding a partially delivered result.
        cons_en = 3'b011; cons_pct = 100; prod_pct = 100;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            got = bus.ack_r[0];
        end
        chk("hold_reached", 32'(got), 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        chk("midrst_ack_r", 32'(bus.ack_r), 32'd0);
        chk("midrst_dout", bus.dout, 32'd0);
        chk("midrst_fire_count", bus.fire_count, 32'd0);
        chk("midrst_overflow", 32'(bus.overflow), 32'd0);
        chk("midrst_req_l", 32'(bus.req_l), 32'd0);
        rst = 1'b0;
        cons_en = '1; cons_pct = 60; prod_pct = 70;
        repeat (200) cycle();

        // Literal operator checks on the subi and max instances.
        prod_pct = 0; cons_en = '0;
        repeat (4) cycle();
        for (int p = 0; p < 2; p++) begin
            bs.din = sub_in[p]; bs.ack_l = 1'b1; bs.req_r = 1'b1;
            cycle();
            bs.ack_l = 1'b0;
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                cycle();
                got = bs.ack_r[0];
            end
            chk("subi_ack", 32'(got), 32'd1);
            chk("subi_dout", bs.dout, sub_exp[p]);
            repeat (2) cycle();
        end
        chk("subi_fire_count", bs.fire_count, 32'd2);
        for (int p = 0; p < 2; p++) begin
            bm.din = mx_in[p]; bm.ack_l = 3'b111; bm.req_r = 1'b1;
            cycle();
            bm.ack_l = 3'b000;
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                cycle();
                got = bm.ack_r[0];
            end
            chk("max_ack", 32'(got), 32'd1);
            chk("max_dout", bm.dout, mx_exp[p]);
            repeat (2) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/elastic_operator.md
ELASTIC_OPERATOR -- requirements
Module: elastic_operator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data word.
REQ-002 Parameter INPUT_SIZE, default 2, number of input channels, legal 1..4.
REQ-003 Parameter OUTPUT_SIZE, default 1, number of output (fan-out) channels, legal 1..8.
REQ-004 Parameter DEPTH, default 4, per-input FIFO entries, legal 2..16.
REQ-005 Parameter OP, default "add", one of "reg","in","out","addi","subi","muli","add","sub","mul","min","max".
REQ-006 Parameter IMMEDIATE, default 0, constant operand for "addi"/"subi"/"muli".
REQ-007 clk  input  1  clock; all state changes on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 req_l  output  INPUT_SIZE  per-input pull request to the upstream producer.
REQ-010 ack_l  input  INPUT_SIZE  per-input one-cycle data-valid pulse from upstream.
REQ-011 din  input  DATA_WIDTH*INPUT_SIZE  input words; channel i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-012 req_r  input  OUTPUT_SIZE  per-output request from downstream consumers.
REQ-013 ack_r  output  OUTPUT_SIZE  per-output one-cycle delivery pulse.
REQ-014 dout  output  DATA_WIDTH  result word, held stable while any output channel is unserved.
REQ-015 fire_count  output  32  number of results produced since reset, wraps at 2^32.
REQ-016 overflow  output  1  sticky flag: an ack_l arrived while its FIFO was full.

Function
REQ-017 Each input i SHALL have a DEPTH-entry FIFO; on ack_l[i] high, din word i is pushed at that edge.
REQ-018 req_l[i] SHALL be registered, next value = 1 iff occupancy of FIFO i after this cycle's push/pop is <= DEPTH-2.
REQ-019 An ack_l[i] with FIFO i full (and no same-cycle pop) SHALL drop the word and set overflow; overflow clears only on rst.
REQ-020 Output stage states: EMPTY (valid=0) and HOLD (valid=1), with served[OUTPUT_SIZE] bits.
REQ-021 In EMPTY, when every FIFO is non-empty, the block SHALL fire: pop all heads, register dout = OP(heads), clear served, enter HOLD, increment fire_count; latency from last required push to HOLD is 1 cycle.
REQ-022 Push and pop on the same FIFO in the same cycle SHALL be legal, occupancy unchanged, including when full.
REQ-023 In HOLD, for each j with req_r[j]=1, served[j]=0, ack_r[j]=0: ack_r[j]<=1 for exactly one cycle and served[j]<=1.
REQ-024 ack_r[j] SHALL never be high for two consecutive cycles; each result is delivered exactly once per output channel.
REQ-025 When served becomes all ones, state SHALL return to EMPTY on the following edge; firing is allowed again from that EMPTY cycle.
REQ-026 Output channels SHALL be served independently; a slow channel stalls only the next fire, not deliveries to other channels.
REQ-027 Arithmetic SHALL be modulo 2^DATA_WIDTH, unsigned; "sub" = in0-in1-in2-in3 (present inputs only); "min"/"max" unsigned compare over present inputs; "reg"/"in"/"out" pass input 0.
REQ-028 Operand order: channel 0 is the first operand.
REQ-029 FIFOs SHALL be strictly in-order per channel; pointers wrap modulo DEPTH.

Reset
REQ-030 On rst: all FIFOs empty, req_l=0, ack_r=0, dout=0, served=0, state EMPTY, fire_count=0, overflow=0.
REQ-031 rst mid-transaction SHALL discard FIFO contents and any held result without emitting ack_r; req_l rises the first cycle after rst deasserts.

Verification
REQ-032 OP="add", INPUT_SIZE=2, producers sending 0,1,2.. and 10,20,30.. -> dout sequence 10,21,32.., fire_count matches consumer count.
REQ-033 OUTPUT_SIZE=3, consumer 2 delays req_r by 10 cycles -> channels 0,1 acked within 2 cycles of HOLD, channel 2 acked once after delay, no refire before it.
REQ-034 DEPTH=2, consumer stalled 50 cycles -> req_l falls after 1 buffered word per input, overflow stays 0, no data lost after resume.
REQ-035 Forced ack_l into full FIFO -> word dropped, overflow=1 until rst.
REQ-036 OP="subi", IMMEDIATE=5, input 3 -> dout=0xFFFFFFFE (DATA_WIDTH=32); OP="max", INPUT_SIZE=3, inputs 7,9,2 -> dout=9.
REQ-037 rst asserted while HOLD with partial serves -> all outputs at reset values next cycle, first post-reset result uses only post-reset inputs.
